// File: rtl/rgmii_idelay_tuner.sv
// Runtime-programmable IDELAYE2 tap controller: per-lane shadow taps, LD/settle/verify sequencing, cfg handshake.
// Optional macro RGMII_IDELAY_STEP_EN swaps the LD load for CE/INC stepping (IDELAY_TYPE = VARIABLE).
module rgmii_idelay_tuner #(
    parameter int LANES         = 5,
    parameter int TAP_W         = 5,
    parameter int INIT_TAP      = 0,
    parameter int SETTLE_CYCLES = 8,
    localparam int LW           = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk_int,
    input  logic                     rst_int_n,
    input  logic                     idelayctrl_rdy,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     cfg_all,
    input  logic [LW-1:0]            cfg_lane,
    input  logic [TAP_W-1:0]         cfg_tap,
    output logic [LANES*TAP_W-1:0]   dly_cntvaluein,
    output logic [LANES-1:0]         dly_ld,
    input  logic [LANES*TAP_W-1:0]   dly_cntvalueout,
    output logic [LANES*TAP_W-1:0]   tap_cur,
    output logic                     busy,
    output logic                     verify_err,
`ifdef RGMII_IDELAY_STEP_EN
    output logic [LANES-1:0]         dly_ce,
    output logic [LANES-1:0]         dly_inc,
`endif
    output logic                     lane_err
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {WAIT_RDY, LOAD, SETTLE, VERIFY, IDLE} state_t;

    state_t                       state_q, state_d;
    logic [LANES-1:0][TAP_W-1:0]  tap_q, tap_d;
    logic [LANES-1:0][TAP_W-1:0]  rb;
    logic [LANES-1:0]             mask_q, mask_d;
    logic [LANES-1:0]             mis;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         verr_q, verr_d;
    logic                         lerr_q, lerr_d;
    logic                         rdy_q;
    logic                         accept;
    logic [31:0]                  lane_ext;
    logic                         lane_ok;
`ifdef RGMII_IDELAY_STEP_EN
    logic                         ph_q, ph_d;
`endif

    assign rb             = dly_cntvalueout;
    assign tap_cur        = tap_q;
    assign dly_cntvaluein = tap_q;
    assign verify_err     = verr_q;
    assign lane_err       = lerr_q;
    // Gating with rdy keeps a ready loss from being seen one cycle late.
    assign cfg_ready      = rdy_q & idelayctrl_rdy;
    assign accept         = cfg_valid & cfg_ready;
    assign lane_ext       = 32'(cfg_lane);
    assign lane_ok        = lane_ext < 32'(LANES);

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            mis[i] = (rb[i] != tap_q[i]);
        end
    end

    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= WAIT_RDY;
            tap_q   <= {LANES{TAP_W'(INIT_TAP)}};
            mask_q  <= '0;
            cnt_q   <= '0;
            verr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef RGMII_IDELAY_STEP_EN
            ph_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            verr_q  <= verr_d;
            lerr_q  <= lerr_d;
            rdy_q   <= (state_d == IDLE);
`ifdef RGMII_IDELAY_STEP_EN
            ph_q    <= ph_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        verr_d  = verr_q;
        lerr_d  = 1'b0;
`ifdef RGMII_IDELAY_STEP_EN
        ph_d    = ph_q;
`endif
        if (!idelayctrl_rdy) begin
            state_d = WAIT_RDY;
        end else begin
            unique case (state_q)
                WAIT_RDY: begin
                    state_d = LOAD;
                    mask_d  = '1;
`ifdef RGMII_IDELAY_STEP_EN
                    ph_d    = 1'b0;
`endif
                end
                LOAD: begin
`ifdef RGMII_IDELAY_STEP_EN
                    // Odd phase gives CNTVALUEOUT a cycle to reflect the last CE.
                    if (ph_q) begin
                        ph_d = 1'b0;
                    end else if ((mis & mask_q) != '0) begin
                        ph_d = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = CW'(SETTLE_CYCLES - 1);
                    end
`else
                    state_d = SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
`endif
                end
                SETTLE: begin
                    if (cnt_q == '0) state_d = VERIFY;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                VERIFY: begin
                    if ((mis & mask_q) != '0) verr_d = 1'b1;
                    state_d = IDLE;
                end
                IDLE: begin
                    if (accept) begin
                        if (cfg_all || lane_ok) begin
                            verr_d  = 1'b0;
                            mask_d  = '0;
                            state_d = LOAD;
`ifdef RGMII_IDELAY_STEP_EN
                            ph_d    = 1'b0;
`endif
                            for (int unsigned i = 0; i < LANES; i++) begin
                                if (cfg_all || lane_ext == i) begin
                                    tap_d[i]  = cfg_tap;
                                    mask_d[i] = 1'b1;
                                end
                            end
                        end else begin
                            lerr_d = 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_RDY;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != IDLE);
        dly_ld = '0;
`ifdef RGMII_IDELAY_STEP_EN
        dly_ce = '0;
        if (state_q == LOAD && !ph_q && idelayctrl_rdy) dly_ce = mis & mask_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            dly_inc[i] = (tap_q[i] > rb[i]);
        end
`else
        if (state_q == LOAD && idelayctrl_rdy) dly_ld = mask_q;
`endif
    end

endmodule

// File: tb/tb_rgmii_idelay_tuner.sv
// Directed self-checking bench for rgmii_idelay_tuner with a behavioural IDELAYE2 tap model.
module tb_rgmii_idelay_tuner;

    localparam int LANES = 5;
    localparam int TAP_W = 5;
    localparam int LW    = 3;
`ifdef RGMII_IDELAY_STEP_EN
    localparam logic [4:0] START_LD = 5'b00000;
`else
    localparam logic [4:0] START_LD = 5'b11111;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   rdy;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_all;
    logic [LW-1:0]          cfg_lane;
    logic [TAP_W-1:0]       cfg_tap;
    logic [LANES*TAP_W-1:0] cin_flat;
    logic [LANES-1:0]       dly_ld;
    logic [LANES*TAP_W-1:0] cout_flat;
    logic [LANES*TAP_W-1:0] tap_cur;
    logic                   busy;
    logic                   verify_err;
    logic                   lane_err;
`ifdef RGMII_IDELAY_STEP_EN
    logic [LANES-1:0]       dly_ce;
    logic [LANES-1:0]       dly_inc;
`endif

    logic [LANES-1:0][TAP_W-1:0] cin;
    logic [LANES-1:0][TAP_W-1:0] cv_q;
    logic                        corrupt4;
    logic [TAP_W-1:0]            exp_tap [LANES];
    int                          checks = 0;
    int                          errors = 0;

    always #5 clk = ~clk;

    rgmii_idelay_tuner #(.LANES(LANES), .TAP_W(TAP_W), .INIT_TAP(0), .SETTLE_CYCLES(8)) dut (
        .clk_int(clk), .rst_int_n(rst_n), .idelayctrl_rdy(rdy),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_all(cfg_all),
        .cfg_lane(cfg_lane), .cfg_tap(cfg_tap),
        .dly_cntvaluein(cin_flat), .dly_ld(dly_ld), .dly_cntvalueout(cout_flat),
        .tap_cur(tap_cur), .busy(busy), .verify_err(verify_err),
`ifdef RGMII_IDELAY_STEP_EN
        .dly_ce(dly_ce), .dly_inc(dly_inc),
`endif
        .lane_err(lane_err)
    );

    // IDELAYE2 counter model; corrupt4 makes lane 4 land one tap low on LD.
    assign cin       = cin_flat;
    assign cout_flat = cv_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (dly_ld[i]) cv_q[i] <= (corrupt4 && i == 4) ? cin[i] - 5'd1 : cin[i];
`ifdef RGMII_IDELAY_STEP_EN
                if (dly_ce[i]) cv_q[i] <= dly_inc[i] ? cv_q[i] + 5'd1 : cv_q[i] - 5'd1;
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 200 && !cfg_ready; n++) @(negedge clk);
        check("ready_wait", cfg_ready, 1);
    endtask

    task automatic count_to_ready(output int n);
        n = 1;
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_taps(input string name);
        for (int i = 0; i < LANES; i++) check(name, tap_cur[i*TAP_W +: TAP_W], exp_tap[i]);
    endtask

    task automatic drive_cfg(input logic all, input logic [LW-1:0] lane, input logic [TAP_W-1:0] tap);
        cfg_valid = 1'b1;
        cfg_all   = all;
        cfg_lane  = lane;
        cfg_tap   = tap;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic             all;
        logic [LW-1:0]    lane;
        logic [TAP_W-1:0] tap;
        logic             corrupt;
        logic [LANES-1:0] exp_ld;
        logic             exp_lerr;
        logic             exp_verr;
    } vec_t;

    task automatic apply_vec(input vec_t v);
        int n;
        corrupt4 = v.corrupt;
        wait_ready();
        drive_cfg(v.all, v.lane, v.tap);
        check("dly_ld", dly_ld, v.exp_ld);
        check("lane_err", lane_err, v.exp_lerr);
        if (v.exp_lerr) begin
            check("ready_held", cfg_ready, 1);
            @(negedge clk);
            check("lane_err_pulse", lane_err, 0);
            check("no_ld", dly_ld, 0);
        end else begin
            for (int i = 0; i < LANES; i++) if (v.all || v.lane == i) exp_tap[i] = v.tap;
            check("ready_low", cfg_ready, 0);
            count_to_ready(n);
            check("cfg_latency", n, 11);
            check("verify_err", verify_err, v.exp_verr);
        end
        check_taps("tap_cur");
    endtask

`ifdef RGMII_IDELAY_STEP_EN
    task automatic step_cfg(input logic [TAP_W-1:0] tap, input int exp_pulses, input logic exp_inc);
        int pulses = 0;
        int ldseen = 0;
        wait_ready();
        drive_cfg(1'b0, 3'd0, tap);
        for (int n = 0; n < 300 && !cfg_ready; n++) begin
            if (dly_ce[0]) begin
                pulses++;
                check("step_inc", dly_inc[0], exp_inc);
            end
            if (dly_ld != '0) ldseen++;
            @(negedge clk);
        end
        check("step_done", cfg_ready, 1);
        check("step_pulses", pulses, exp_pulses);
        check("step_no_ld", ldseen, 0);
        check("step_readback", cv_q[0], tap);
        check("step_verify", verify_err, 0);
    endtask
`endif

    vec_t vecs [8];

    initial begin
        int n;
        vecs[0] = '{1'b0, 3'd2, 5'd13, 1'b0, 5'b00100, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 5'd31, 1'b1, 5'b11111, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 3'd0, 5'd5,  1'b0, 5'b00001, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'd6, 5'd7,  1'b0, 5'b00000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'd5, 5'd7,  1'b0, 5'b00000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 3'd4, 5'd17, 1'b0, 5'b10000, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 3'd3, 5'd0,  1'b0, 5'b01000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 3'd7, 5'd10, 1'b0, 5'b11111, 1'b0, 1'b0};
        for (int i = 0; i < LANES; i++) exp_tap[i] = '0;

        rst_n = 1'b0; rdy = 1'b0; cfg_valid = 1'b0; cfg_all = 1'b0;
        cfg_lane = '0; cfg_tap = '0; corrupt4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", cfg_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_verr", verify_err, 0);
        check("rst_lerr", lane_err, 0);
        check("rst_ld", dly_ld, 0);
        check("rst_taps", tap_cur, 0);
        check("rst_cin", cin_flat, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_ready_low", cfg_ready, 0);
        check("wait_no_ld", dly_ld, 0);
        rdy = 1'b1;
        @(negedge clk);
        check("start_ld", dly_ld, START_LD);
        @(negedge clk);
        check("start_ld_once", dly_ld, 0);
        count_to_ready(n);
        check("start_latency", n, 10);
        check("idle_busy", busy, 0);

`ifdef RGMII_IDELAY_STEP_EN
        step_cfg(5'd3, 3, 1'b1);
        step_cfg(5'd7, 4, 1'b1);
        step_cfg(5'd2, 5, 1'b0);
`else
        for (int v = 0; v < 8; v++) apply_vec(vecs[v]);

        // Ready loss during SETTLE, then reload of current shadows.
        wait_ready();
        drive_cfg(1'b0, 3'd1, 5'd9);
        exp_tap[1] = 5'd9;
        check("drop_ld", dly_ld, 5'b00010);
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        check("drop_busy", busy, 1);
        check("drop_ready", cfg_ready, 0);
        repeat (5) @(negedge clk);
        check("drop_hold_ld", dly_ld, 0);
        check("drop_hold_ready", cfg_ready, 0);
        rdy = 1'b1;
        @(negedge clk);
        check("reload_ld", dly_ld, 5'b11111);
        check("reload_lane1", cin[1], 9);
        @(negedge clk);
        count_to_ready(n);
        check("reload_latency", n, 10);
        check("reload_verr", verify_err, 0);
        check_taps("reload_taps");

        // Asynchronous reset mid-operation restores INIT_TAP.
        wait_ready();
        drive_cfg(1'b1, 3'd0, 5'd21);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_taps", tap_cur, 0);
        check("arst_busy", busy, 1);
        check("arst_ready", cfg_ready, 0);
        check("arst_ld", dly_ld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_reload_ld", dly_ld, 5'b11111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rgmii_idelay_tuner.md
Name: rgmii_idelay_tuner

Overview:
- Runtime-programmable successor to the fixed-delay RGMII receive path.
- Drives VAR_LOAD-mode IDELAYE2 elements on LANES receive inputs (default: 4 rxd + rx_ctl) from a per-lane tap shadow register.
- Provides a valid/ready configuration port (per-lane or broadcast) and loads INIT_TAP on every lane once IDELAYCTRL reports ready.
- Verifies each load by comparing CNTVALUEOUT read-back against the shadow. Sits between the soc wrapper's delay primitives and a CSR block.

Parameters:
- LANES, 5, number of delayed inputs (1..16)
- TAP_W, 5, tap value width (IDELAYE2 = 5)
- INIT_TAP, 0, tap loaded into every lane after IDELAYCTRL ready
- SETTLE_CYCLES, 8, wait after LD before read-back compare (>=1)

Ports:
- clk_int  in  1  delay-control clock; same clock drives IDELAYE2 C
- rst_int_n  in  1  asynchronous active-low reset
- idelayctrl_rdy  in  1  IDELAYCTRL RDY, treated as synchronous to clk_int
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
- cfg_all  in  1  broadcast cfg_tap to all lanes; cfg_lane ignored
- cfg_lane  in  $clog2(LANES) (min 1)  target lane
- cfg_tap  in  TAP_W  requested tap
- dly_cntvaluein  out  LANES*TAP_W  to IDELAYE2 CNTVALUEIN, lane i at [i*TAP_W +: TAP_W]
- dly_ld  out  LANES  per-lane LD strobe
- dly_cntvalueout  in  LANES*TAP_W  IDELAYE2 CNTVALUEOUT
- tap_cur  out  LANES*TAP_W  shadow taps
- busy  out  1  high in every state except IDLE
- verify_err  out  1  sticky read-back mismatch
- lane_err  out  1  one-cycle pulse on an accepted out-of-range lane

Behaviour:
Reset values:
- All shadows = INIT_TAP; dly_cntvaluein = shadows; dly_ld = 0.
- cfg_ready = 0, busy = 1, verify_err = 0, lane_err = 0. State WAIT_RDY.

States:
- WAIT_RDY: hold until idelayctrl_rdy = 1, then go to LOAD with mask = all lanes.
- LOAD: dly_cntvaluein already equals the shadows (updated the cycle before). Assert dly_ld[mask] for exactly one cycle. Go to SETTLE; counter = SETTLE_CYCLES-1.
- SETTLE: decrement counter; at 0 go to VERIFY.
- VERIFY (1 cycle): for each lane in mask, compare dly_cntvalueout to its shadow. Any mismatch sets verify_err. Go to IDLE.
- IDLE: cfg_ready = 1, busy = 0.

Configuration handshake (in IDLE):
- A request is accepted on the cycle cfg_valid && cfg_ready.
- On acceptance, clear verify_err and write the shadow(s): all lanes if cfg_all, else cfg_lane. Next state is LOAD with mask = the written lanes.
- cfg_ready is registered: it is 0 in the cycle after acceptance and stays 0 until IDLE is reached again.
- Load latency: dly_ld is asserted 1 cycle after acceptance. Back to IDLE 3+SETTLE_CYCLES cycles after acceptance.
- If !cfg_all and cfg_lane >= LANES: pulse lane_err, leave shadows unchanged, stay in IDLE.

Ready loss:
- If idelayctrl_rdy = 0 in any state, go to WAIT_RDY immediately: deassert dly_ld and cfg_ready, abort settle.
- On recovery, reload all lanes from their current shadows, not from INIT_TAP.

Other rules:
- cfg_tap is taken modulo 2^TAP_W; no saturation.
- Asynchronous reset mid-operation returns to WAIT_RDY with shadows = INIT_TAP.

Optional Feature:
- Macro: RGMII_IDELAY_STEP_EN.
- Defined:
  - Adds outputs dly_ce[LANES] and dly_inc[LANES]; IDELAY_TYPE becomes VARIABLE.
  - LOAD is replaced by STEP: each masked lane whose read-back differs from its shadow gets one CE pulse per 2 cycles. dly_inc = 1 if the target is greater than the read-back, else 0.
  - No LD pulses. STEP ends when every masked read-back equals its shadow, then SETTLE follows.
  - Wrap-around is forbidden: the step direction always follows the numeric difference.
- Undefined: those ports are absent and the behaviour above applies.

Test Plan:
- Reset with idelayctrl_rdy = 0 for 20 cycles, then 1 -> dly_ld = 5'b11111 for one cycle 1 cycle after rdy rises; with INIT_TAP=0, cfg_ready rises 3+8 cycles after rdy.
- IDLE, cfg lane 2 tap 13, model returns 13 -> dly_ld = 5'b00100, lane 2 of tap_cur = 13, verify_err = 0, other lanes unchanged.
- Broadcast tap 31, model returns 30 on lane 4 -> dly_ld = 5'b11111, verify_err = 1; next accepted cfg clears it.
- cfg_lane = 6, cfg_all = 0 -> lane_err pulse, no dly_ld, cfg_ready stays 1.
- Drop rdy during SETTLE after lane 1 is set to 9 -> WAIT_RDY; on recovery all lanes reload and lane 1 = 9, not INIT_TAP.
- STEP_EN, lane 0 from 3 to 7 -> exactly 4 dly_ce pulses with dly_inc = 1, no dly_ld.
